// File: rtl/mem_load_sequencer_if.sv
// MEM-stage load sequencer bus: pipeline-side op inputs, byte-wide data-memory
// read handshake, and the MEM/WB mux select / load result outputs.
interface mem_load_sequencer_if;
  logic        mem_op_valid;
  logic [1:0]  op_type;
  logic [15:0] mem_addr;
  logic        dmem_req;
  logic [15:0] dmem_addr;
  logic [7:0]  dmem_rdata;
  logic        dmem_ack;
  logic [3:0]  sel_signals;
  logic [7:0]  ld_res_top;
  logic [7:0]  ld_res_bot;
  logic        stall;
  logic        ld_done;
  logic        bus_err;

  // Driver side: pipeline plus data memory.
  modport master (
    output mem_op_valid, op_type, mem_addr, dmem_rdata, dmem_ack,
    input  dmem_req, dmem_addr, sel_signals, ld_res_top, ld_res_bot,
           stall, ld_done, bus_err
  );

  // Sequencer side.
  modport slave (
    input  mem_op_valid, op_type, mem_addr, dmem_rdata, dmem_ack,
    output dmem_req, dmem_addr, sel_signals, ld_res_top, ld_res_bot,
           stall, ld_done, bus_err
  );
endinterface

// File: rtl/mem_load_sequencer.sv
// MEM-stage load sequencer: drives the MEM/WB select bus and runs the 1- or 2-beat
// byte-wide load handshake. Optional read-beat timeout under MEM_LOAD_TIMEOUT_EN.
module mem_load_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_load_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_LO    = 2'd1,
    RD_HI    = 2'd2,
    COMPLETE = 2'd3
  } state_e;

  localparam logic [3:0] SEL_PASS  = 4'b0100;
  localparam logic [3:0] SEL_SFR   = 4'b0010;
  localparam logic [3:0] SEL_LDRES = 4'b1001;

  state_e      state_q, state_d;
  logic        word_q, word_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  top_q, top_d;
  logic [7:0]  bot_q, bot_d;
  logic        berr_q, berr_d;

  logic [3:0]  sel;
  logic        stall;
  logic        req;
  logic [15:0] raddr;
  logic        beat_ack;
  logic        beat_abort;

  assign beat_ack = req & bus.dmem_ack;

`ifdef MEM_LOAD_TIMEOUT_EN
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_CYCLES - 1);

  logic [3:0] wait_q, wait_d;

  // Counter restarts on every state change, so each beat gets a fresh budget.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) wait_d = 4'd0;
    else if (req && !bus.dmem_ack) wait_d = wait_q + 4'd1;
  end

  // Ack in the final cycle still wins over the abort.
  assign beat_abort = req && !bus.dmem_ack && (wait_q == WAIT_LAST);

  always_ff @(posedge clock) begin
    if (reset) wait_q <= 4'd0;
    else       wait_q <= wait_d;
  end
`else
  assign beat_abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    addr_d  = addr_q;
    top_d   = top_q;
    bot_d   = bot_q;
    berr_d  = berr_q;
    sel     = SEL_PASS;
    stall   = 1'b0;
    req     = 1'b0;
    raddr   = 16'h0000;

    case (state_q)
      IDLE: begin
        if (bus.mem_op_valid) begin
          if (bus.op_type == 2'b01) begin
            sel = SEL_SFR;
          end else if (bus.op_type[1]) begin
            word_d  = bus.op_type[0];
            addr_d  = bus.mem_addr;
            berr_d  = 1'b0;
            stall   = 1'b1;
            state_d = RD_LO;
          end
        end
      end

      RD_LO: begin
        req   = 1'b1;
        raddr = addr_q;
        stall = 1'b1;
        if (beat_ack) begin
          bot_d = bus.dmem_rdata;
          if (word_q) begin
            state_d = RD_HI;
          end else begin
            top_d   = 8'h00;
            state_d = COMPLETE;
          end
        end else if (beat_abort) begin
          // Missing bytes read as all-ones; a byte load still zero-extends.
          bot_d   = 8'hFF;
          top_d   = word_q ? 8'hFF : 8'h00;
          berr_d  = 1'b1;
          state_d = COMPLETE;
        end
      end

      RD_HI: begin
        req   = 1'b1;
        raddr = addr_q + 16'd1;
        stall = 1'b1;
        if (beat_ack) begin
          top_d   = bus.dmem_rdata;
          state_d = COMPLETE;
        end else if (beat_abort) begin
          top_d   = 8'hFF;
          berr_d  = 1'b1;
          state_d = COMPLETE;
        end
      end

      COMPLETE: begin
        sel     = SEL_LDRES;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Reset also discards any partial load result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= 1'b0;
      addr_q  <= 16'h0000;
      top_q   <= 8'h00;
      bot_q   <= 8'h00;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      berr_q  <= berr_d;
    end
  end

  assign bus.sel_signals = sel;
  assign bus.stall       = stall;
  assign bus.dmem_req    = req;
  assign bus.dmem_addr   = raddr;
  assign bus.ld_res_top  = top_q;
  assign bus.ld_res_bot  = bot_q;
  assign bus.ld_done     = (state_q == COMPLETE);
`ifdef MEM_LOAD_TIMEOUT_EN
  assign bus.bus_err     = (state_q == COMPLETE) && berr_q;
`else
  assign bus.bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_load_sequencer.sv
// Randomized bench for mem_load_sequencer; expected results come from a
// per-load model of beat counts, addresses and assembled bytes.
module tb_mem_load_sequencer;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  mem_load_sequencer_if bus ();

  mem_load_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Drives one load through the bench-side memory with the given wait states
  // and checks every cycle against the expected sequence.
  task automatic run_load(input bit word, input logic [15:0] addr,
                          input int wlo, input int whi,
                          input logic [7:0] dlo, input logic [7:0] dhi,
                          input bit corrupt);
    int          nst;
    int          exp_st;
    int          nw;
    logic [15:0] ea;
    logic [7:0]  et;
    logic [7:0]  eb;
    et     = word ? dhi : 8'h00;
    eb     = dlo;
    exp_st = 1 + (wlo + 1) + (word ? (whi + 1) : 0);
    nst    = 0;

    @(negedge clock);
    bus.mem_op_valid = 1'b1;
    bus.op_type      = {1'b1, word};
    bus.mem_addr     = addr;
    bus.dmem_ack     = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 1'b1 || bus.sel_signals !== 4'b0100 || bus.dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL detect: stall=%b sel=%b req=%b, expected 1 0100 0",
               bus.stall, bus.sel_signals, bus.dmem_req);
    end
    if (bus.stall === 1'b1) nst++;

    for (int b = 0; b < (word ? 2 : 1); b++) begin
      ea = (b == 0) ? addr : addr + 16'd1;
      nw = (b == 0) ? wlo : whi;
      for (int w = 0; w <= nw; w++) begin
        @(negedge clock);
        if (corrupt) begin
          bus.mem_op_valid = 1'($urandom);
          bus.op_type      = 2'($urandom);
          bus.mem_addr     = 16'($urandom);
        end
        bus.dmem_ack   = (w == nw);
        bus.dmem_rdata = (w == nw) ? ((b == 0) ? dlo : dhi) : 8'($urandom);
        #1;
        checks++;
        if (bus.dmem_req !== 1'b1 || bus.dmem_addr !== ea || bus.stall !== 1'b1 ||
            bus.sel_signals !== 4'b0100) begin
          errors++;
          $display("FAIL beat%0d: req=%b addr=%h stall=%b sel=%b, expected 1 %h 1 0100",
                   b, bus.dmem_req, bus.dmem_addr, bus.stall, bus.sel_signals, ea);
        end
        if (bus.stall === 1'b1) nst++;
      end
    end

    @(negedge clock);
    bus.dmem_ack     = 1'b0;
    bus.mem_op_valid = 1'b0;
    bus.op_type      = 2'b00;
    #1;
    checks++;
    if (bus.sel_signals !== 4'b1001 || bus.stall !== 1'b0 || bus.ld_done !== 1'b1 ||
        bus.bus_err !== 1'b0 || bus.dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL complete: sel=%b stall=%b done=%b err=%b req=%b, expected 1001 0 1 0 0",
               bus.sel_signals, bus.stall, bus.ld_done, bus.bus_err, bus.dmem_req);
    end
    checks++;
    if (bus.ld_res_top !== et || bus.ld_res_bot !== eb) begin
      errors++;
      $display("FAIL result: top=%h bot=%h, expected %h %h",
               bus.ld_res_top, bus.ld_res_bot, et, eb);
    end
    checks++;
    if (nst != exp_st) begin
      errors++;
      $display("FAIL stall_len: got %0d cycles, expected %0d", nst, exp_st);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_op_valid = 1'b0;
    bus.op_type      = 2'b00;
    bus.mem_addr     = 16'h0000;
    bus.dmem_rdata   = 8'h00;
    bus.dmem_ack     = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.dmem_addr !== 16'h0000 || bus.ld_res_top !== 8'h00 ||
        bus.ld_res_bot !== 8'h00 || bus.stall !== 1'b0 || bus.ld_done !== 1'b0 ||
        bus.bus_err !== 1'b0 || bus.sel_signals !== 4'b0100) begin
      errors++;
      $display("FAIL reset: req=%b addr=%h top=%h bot=%h stall=%b done=%b err=%b sel=%b",
               bus.dmem_req, bus.dmem_addr, bus.ld_res_top, bus.ld_res_bot,
               bus.stall, bus.ld_done, bus.bus_err, bus.sel_signals);
    end
  endtask

  task automatic test_passthrough();
    logic [3:0] exp_sel [3] = '{4'b0100, 4'b0010, 4'b0100};
    logic [1:0] ops     [3] = '{2'b00, 2'b01, 2'b10};
    logic       vld     [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus.mem_op_valid = vld[i];
      bus.op_type      = ops[i];
      bus.mem_addr     = 16'($urandom);
      #1;
      checks++;
      if (bus.sel_signals !== exp_sel[i] || bus.stall !== 1'b0 || bus.dmem_req !== 1'b0 ||
          bus.ld_done !== 1'b0) begin
        errors++;
        $display("FAIL pass%0d: sel=%b stall=%b req=%b done=%b, expected %b 0 0 0",
                 i, bus.sel_signals, bus.stall, bus.dmem_req, bus.ld_done, exp_sel[i]);
      end
    end
  endtask

  task automatic test_byte_load();
    run_load(1'b0, 16'h1234, 0, 0, 8'hA5, 8'h00, 1'b0);
  endtask

  task automatic test_word_wrap();
    run_load(1'b1, 16'hFFFF, 2, 2, 8'h34, 8'h12, 1'b0);
  endtask

  task automatic test_corrupt_inputs();
    run_load(1'b0, 16'h4321, 1, 0, 8'h5A, 8'h00, 1'b1);
    run_load(1'b1, 16'h8000, 1, 3, 8'hC3, 8'h3C, 1'b1);
  endtask

  task automatic test_hold();
    logic [7:0] t;
    logic [7:0] b;
    t = bus.ld_res_top;
    b = bus.ld_res_bot;
    repeat (2) begin
      @(negedge clock);
      bus.mem_op_valid = 1'b1;
      bus.op_type      = 2'($urandom_range(0, 1));
      bus.dmem_ack     = 1'b1;
      #1;
      checks++;
      if (bus.ld_res_top !== t || bus.ld_res_bot !== b || bus.ld_done !== 1'b0 ||
          bus.dmem_req !== 1'b0) begin
        errors++;
        $display("FAIL hold: top=%h bot=%h done=%b req=%b, expected %h %h 0 0",
                 bus.ld_res_top, bus.ld_res_bot, bus.ld_done, bus.dmem_req, t, b);
      end
    end
    bus.dmem_ack     = 1'b0;
    bus.mem_op_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_load(1'b1, 16'h0100, 0, 0, 8'h11, 8'h22, 1'b0);
    run_load(1'b0, 16'h0102, 0, 0, 8'h33, 8'h00, 1'b0);
    run_load(1'b1, 16'h0104, 1, 0, 8'h44, 8'h55, 1'b0);
  endtask

  task automatic test_random_loads();
    for (int i = 0; i < 25; i++) begin
      run_load(1'($urandom), (i % 5 == 0) ? 16'hFFFF : 16'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               8'($urandom), 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clock);
    bus.mem_op_valid = 1'b1;
    bus.op_type      = 2'b11;
    bus.mem_addr     = 16'h2000;
    @(negedge clock);
    bus.mem_op_valid = 1'b0;
    bus.dmem_ack     = 1'b1;
    bus.dmem_rdata   = 8'h77;
    @(negedge clock);
    bus.dmem_ack     = 1'b0;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b1 || bus.dmem_addr !== 16'h2001 || bus.ld_res_bot !== 8'h77) begin
      errors++;
      $display("FAIL pre_reset: req=%b addr=%h bot=%h, expected 1 2001 77",
               bus.dmem_req, bus.dmem_addr, bus.ld_res_bot);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.ld_res_top !== 8'h00 || bus.ld_res_bot !== 8'h00 ||
        bus.stall !== 1'b0 || bus.ld_done !== 1'b0 || bus.sel_signals !== 4'b0100) begin
      errors++;
      $display("FAIL mid_reset: req=%b top=%h bot=%h stall=%b done=%b sel=%b",
               bus.dmem_req, bus.ld_res_top, bus.ld_res_bot, bus.stall, bus.ld_done,
               bus.sel_signals);
    end
  endtask

`ifdef MEM_LOAD_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clock);
    bus.mem_op_valid = 1'b1;
    bus.op_type      = 2'b11;
    bus.mem_addr     = 16'h0F00;
    bus.dmem_ack     = 1'b0;
    for (int w = 0; w < 4; w++) begin
      @(negedge clock);
      bus.mem_op_valid = 1'b0;
      #1;
      checks++;
      if (bus.dmem_req !== 1'b1 || bus.dmem_addr !== 16'h0F00) begin
        errors++;
        $display("FAIL to_wait%0d: req=%b addr=%h, expected 1 0f00",
                 w, bus.dmem_req, bus.dmem_addr);
      end
    end
    @(negedge clock);
    #1;
    checks++;
    if (bus.ld_done !== 1'b1 || bus.bus_err !== 1'b1 || bus.ld_res_top !== 8'hFF ||
        bus.ld_res_bot !== 8'hFF) begin
      errors++;
      $display("FAIL timeout: done=%b err=%b top=%h bot=%h, expected 1 1 ff ff",
               bus.ld_done, bus.bus_err, bus.ld_res_top, bus.ld_res_bot);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_byte_load();
    test_hold();
    test_word_wrap();
    test_corrupt_inputs();
    test_back_to_back();
    test_random_loads();
    test_hold();
    test_reset_mid_load();
`ifdef MEM_LOAD_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
